// File: rtl/uart_mdb_master_if.sv
// UART host-side bus between the multidrop master and the uartx2 control/status/data port.
interface uart_mdb_master_if;
   logic [7:0] uart_control;
   logic [7:0] uart_txdata;
   logic       uart_write_tx;
   logic       uart_tx_empty;
   logic [7:0] uart_status;
   logic [7:0] uart_rxdata;
   logic       uart_rx_valid;
   logic       uart_read_rx;

   modport master (
      output uart_control, uart_txdata, uart_write_tx, uart_read_rx,
      input  uart_tx_empty, uart_status, uart_rxdata, uart_rx_valid
   );

   modport slave (
      input  uart_control, uart_txdata, uart_write_tx, uart_read_rx,
      output uart_tx_empty, uart_status, uart_rxdata, uart_rx_valid
   );
endinterface

// File: rtl/uart_mdb_master.sv
// Multidrop (9-bit address mode) bus master for the uartx2 host port.
// Sends an address byte (ninth bit 1) plus payload, then collects a response
// with an inter-byte timeout. Optional feature macro: UART_MDB_CHECKSUM_EN
// (XOR checksum byte appended on transmit and expected on receive).
module uart_mdb_master #(
   parameter int unsigned LEN_W = 5,
   parameter int unsigned TMO_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req,
   input  logic [7:0]       i_req_addr,
   input  logic [LEN_W-1:0] i_req_len,
   input  logic [LEN_W-1:0] i_resp_len,
   input  logic [TMO_W-1:0] i_timeout,
   input  logic [7:0]       i_wr_data,
   output logic             o_wr_pop,
   output logic             o_busy,
   output logic             o_done,
   output logic [7:0]       o_resp_data,
   output logic             o_resp_valid,
   output logic [LEN_W-1:0] o_resp_count,
   output logic             o_err_timeout,
   output logic             o_err_rx,
   output logic             o_err_csum,
   uart_mdb_master_if.master io_uart
);

`ifdef UART_MDB_CHECKSUM_EN
   localparam logic CSUM_EN = 1'b1;
`else
   localparam logic CSUM_EN = 1'b0;
`endif

   localparam int unsigned   CNT_W    = LEN_W + 1;
   localparam logic [LEN_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]    CTRL_RST = 8'h53;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_TXW   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_RX    = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   logic [2:0]       r_state,      w_state_nxt;
   logic [7:0]       r_addr,       w_addr_nxt;
   logic [LEN_W-1:0] r_rem,        w_rem_nxt;
   logic [LEN_W-1:0] r_resp_len,   w_resp_len_nxt;
   logic [TMO_W-1:0] r_tmo_ld,     w_tmo_ld_nxt;
   logic [TMO_W-1:0] r_tmo,        w_tmo_nxt;
   logic [CNT_W-1:0] r_rcv,        w_rcv_nxt;
   logic [7:0]       r_rx_byte,    w_rx_byte_nxt;
   logic [7:0]       r_csum_tx,    w_csum_tx_nxt;
   logic [7:0]       r_csum_rx,    w_csum_rx_nxt;
   logic             r_csum_sent,  w_csum_sent_nxt;
   logic             r_wr_pop,     w_wr_pop_nxt;
   logic             r_busy,       w_busy_nxt;
   logic             r_done,       w_done_nxt;
   logic [7:0]       r_resp_data,  w_resp_data_nxt;
   logic             r_resp_valid, w_resp_valid_nxt;
   logic [LEN_W-1:0] r_resp_count, w_resp_count_nxt;
   logic             r_err_tmo,    w_err_tmo_nxt;
   logic             r_err_rx,     w_err_rx_nxt;
   logic             r_err_csum,   w_err_csum_nxt;
   logic [7:0]       r_control,    w_control_nxt;
   logic [7:0]       r_txdata,     w_txdata_nxt;
   logic             r_write_tx,   w_write_tx_nxt;
   logic             r_read_rx,    w_read_rx_nxt;

   logic [CNT_W-1:0] w_rx_total;
   logic             w_rx_bad;

   // Response bytes expected on the wire, including the checksum byte when enabled.
   assign w_rx_total = CNT_W'(r_resp_len) + CNT_W'(CSUM_EN);
   assign w_rx_bad   = |(io_uart.uart_status & 8'h3C);

   // State register and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_rem        <= '0;
         r_resp_len   <= '0;
         r_tmo_ld     <= '0;
         r_tmo        <= '0;
         r_rcv        <= '0;
         r_rx_byte    <= '0;
         r_csum_tx    <= '0;
         r_csum_rx    <= '0;
         r_csum_sent  <= 1'b0;
         r_wr_pop     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_resp_data  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_count <= '0;
         r_err_tmo    <= 1'b0;
         r_err_rx     <= 1'b0;
         r_err_csum   <= 1'b0;
         r_control    <= CTRL_RST;
         r_txdata     <= '0;
         r_write_tx   <= 1'b0;
         r_read_rx    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_rem        <= w_rem_nxt;
         r_resp_len   <= w_resp_len_nxt;
         r_tmo_ld     <= w_tmo_ld_nxt;
         r_tmo        <= w_tmo_nxt;
         r_rcv        <= w_rcv_nxt;
         r_rx_byte    <= w_rx_byte_nxt;
         r_csum_tx    <= w_csum_tx_nxt;
         r_csum_rx    <= w_csum_rx_nxt;
         r_csum_sent  <= w_csum_sent_nxt;
         r_wr_pop     <= w_wr_pop_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_resp_data  <= w_resp_data_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_count <= w_resp_count_nxt;
         r_err_tmo    <= w_err_tmo_nxt;
         r_err_rx     <= w_err_rx_nxt;
         r_err_csum   <= w_err_csum_nxt;
         r_control    <= w_control_nxt;
         r_txdata     <= w_txdata_nxt;
         r_write_tx   <= w_write_tx_nxt;
         r_read_rx    <= w_read_rx_nxt;
      end
   end

   // Next-state and next-output logic; pulses default low, everything else holds.
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_rem_nxt        = r_rem;
      w_resp_len_nxt   = r_resp_len;
      w_tmo_ld_nxt     = r_tmo_ld;
      w_tmo_nxt        = r_tmo;
      w_rcv_nxt        = r_rcv;
      w_rx_byte_nxt    = r_rx_byte;
      w_csum_tx_nxt    = r_csum_tx;
      w_csum_rx_nxt    = r_csum_rx;
      w_csum_sent_nxt  = r_csum_sent;
      w_resp_data_nxt  = r_resp_data;
      w_resp_count_nxt = r_resp_count;
      w_err_tmo_nxt    = r_err_tmo;
      w_err_rx_nxt     = r_err_rx;
      w_err_csum_nxt   = r_err_csum;
      w_control_nxt    = r_control;
      w_txdata_nxt     = r_txdata;
      w_wr_pop_nxt     = 1'b0;
      w_done_nxt       = 1'b0;
      w_resp_valid_nxt = 1'b0;
      w_write_tx_nxt   = 1'b0;
      w_read_rx_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               w_addr_nxt       = i_req_addr;
               w_rem_nxt        = i_req_len;
               w_resp_len_nxt   = i_resp_len;
               w_tmo_ld_nxt     = i_timeout;
               w_rcv_nxt        = '0;
               w_csum_tx_nxt    = i_req_addr;
               w_csum_rx_nxt    = '0;
               w_csum_sent_nxt  = 1'b0;
               w_resp_count_nxt = '0;
               w_err_tmo_nxt    = 1'b0;
               w_err_rx_nxt     = 1'b0;
               w_err_csum_nxt   = 1'b0;
               w_control_nxt[7] = 1'b1;
               w_state_nxt      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (io_uart.uart_tx_empty) begin
               w_txdata_nxt   = r_addr;
               w_write_tx_nxt = 1'b1;
               w_state_nxt    = S_TXW;
            end
         end
         S_TXW: begin
            // The write pulse cycle itself still sees the stale empty flag.
            if (!r_write_tx && io_uart.uart_tx_empty) begin
               if (r_rem != '0 || (CSUM_EN && !r_csum_sent)) begin
                  w_control_nxt[7] = 1'b0;
                  w_state_nxt      = S_DATA;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DATA: begin
            if (io_uart.uart_tx_empty) begin
               w_write_tx_nxt = 1'b1;
               w_state_nxt    = S_TXW;
               if (r_rem != '0) begin
                  w_txdata_nxt  = i_wr_data;
                  w_wr_pop_nxt  = 1'b1;
                  w_rem_nxt     = r_rem - LEN_W'(1);
                  w_csum_tx_nxt = r_csum_tx ^ i_wr_data;
               end else begin
                  w_txdata_nxt    = r_csum_tx;
                  w_csum_sent_nxt = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (w_rx_total != '0) begin
               w_tmo_nxt   = r_tmo_ld;
               w_state_nxt = S_RX;
            end else begin
               w_state_nxt = S_FIN;
            end
         end
         S_RX: begin
            if (r_read_rx) begin
               // Gap cycle after a read: present the captured byte, ignore rx_valid.
               if (r_rcv < CNT_W'(r_resp_len)) begin
                  w_resp_valid_nxt = 1'b1;
                  w_resp_data_nxt  = r_rx_byte;
                  w_csum_rx_nxt    = r_csum_rx ^ r_rx_byte;
                  if (r_resp_count != CNT_MAX) begin
                     w_resp_count_nxt = r_resp_count + LEN_W'(1);
                  end
               end else begin
                  w_err_csum_nxt = r_err_csum | (CSUM_EN & (r_rx_byte != r_csum_rx));
               end
               w_rcv_nxt = r_rcv + CNT_W'(1);
               if (r_rcv + CNT_W'(1) == w_rx_total) begin
                  w_state_nxt = S_FIN;
               end
            end else if (io_uart.uart_rx_valid) begin
               w_read_rx_nxt = 1'b1;
               w_rx_byte_nxt = io_uart.uart_rxdata;
               w_err_rx_nxt  = r_err_rx | w_rx_bad;
               w_tmo_nxt     = r_tmo_ld;
            end else if (r_tmo == '0) begin
               w_err_tmo_nxt = 1'b1;
               w_state_nxt   = S_FIN;
            end else begin
               w_tmo_nxt = r_tmo - TMO_W'(1);
            end
         end
         S_FIN: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Stray receive bytes outside the response phase are read and dropped.
      if ((r_state == S_IDLE || r_state == S_ADDR || r_state == S_TXW || r_state == S_DATA) &&
          io_uart.uart_rx_valid && !r_read_rx) begin
         w_read_rx_nxt = 1'b1;
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign o_wr_pop              = r_wr_pop;
   assign o_busy                = r_busy;
   assign o_done                = r_done;
   assign o_resp_data           = r_resp_data;
   assign o_resp_valid          = r_resp_valid;
   assign o_resp_count          = r_resp_count;
   assign o_err_timeout         = r_err_tmo;
   assign o_err_rx              = r_err_rx;
   assign o_err_csum            = r_err_csum;
   assign io_uart.uart_control  = r_control;
   assign io_uart.uart_txdata   = r_txdata;
   assign io_uart.uart_write_tx = r_write_tx;
   assign io_uart.uart_read_rx  = r_read_rx;

endmodule

// File: tb/tb_uart_mdb_master.sv
// Self-checking bench for uart_mdb_master: behavioural UART/slave model,
// directed scenarios plus randomized transactions against a frame-level reference.
module tb_uart_mdb_master;
   localparam int unsigned LEN_W = 5;
   localparam int unsigned TMO_W = 16;
`ifdef UART_MDB_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             req;
   logic [7:0]       req_addr;
   logic [LEN_W-1:0] req_len;
   logic [LEN_W-1:0] resp_len;
   logic [TMO_W-1:0] timeout;
   logic [7:0]       wr_data;
   logic             wr_pop, busy, done, resp_valid;
   logic [7:0]       resp_data;
   logic [LEN_W-1:0] resp_count;
   logic             err_timeout, err_rx, err_csum;

   uart_mdb_master_if u_if ();

   uart_mdb_master #(.LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_req         (req),
      .i_req_addr    (req_addr),
      .i_req_len     (req_len),
      .i_resp_len    (resp_len),
      .i_timeout     (timeout),
      .i_wr_data     (wr_data),
      .o_wr_pop      (wr_pop),
      .o_busy        (busy),
      .o_done        (done),
      .o_resp_data   (resp_data),
      .o_resp_valid  (resp_valid),
      .o_resp_count  (resp_count),
      .o_err_timeout (err_timeout),
      .o_err_rx      (err_rx),
      .o_err_csum    (err_csum),
      .io_uart       (u_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Model state
   logic [8:0] tx_seen[$];
   logic [7:0] rxq_data[$];
   logic [7:0] rxq_stat[$];
   logic [7:0] got[$];
   logic [7:0] payload [0:31];
   logic [7:0] resp_buf [0:31];
   int  pops, dones, proto_err, cyc_now, t_first_resp, t_done;
   int  tx_busy, rx_dly;
   logic prev_wr, prev_rd;

   // UART + slave model; evaluated on the falling edge so the DUT samples stable inputs.
   initial begin
      u_if.uart_tx_empty = 1'b1;
      u_if.uart_rx_valid = 1'b0;
      u_if.uart_rxdata   = 8'h00;
      u_if.uart_status   = 8'h00;
      tx_busy = 0; rx_dly = 0; proto_err = 0; cyc_now = 0;
      prev_wr = 1'b0; prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         cyc_now++;
         if (u_if.uart_write_tx && prev_wr) proto_err++;
         if (u_if.uart_read_rx && prev_rd) proto_err++;
         prev_wr = u_if.uart_write_tx;
         prev_rd = u_if.uart_read_rx;
         if (u_if.uart_write_tx) begin
            tx_seen.push_back({u_if.uart_control[7], u_if.uart_txdata});
            tx_busy = $urandom_range(3, 10);
            u_if.uart_tx_empty = 1'b0;
         end else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) u_if.uart_tx_empty = 1'b1;
         end
         if (wr_pop) begin
            pops++;
            wr_data = payload[pops % 32];
         end
         if (resp_valid) begin
            if (got.size() == 0) t_first_resp = cyc_now;
            got.push_back(resp_data);
         end
         if (done) begin
            dones++;
            t_done = cyc_now;
         end
         if (u_if.uart_read_rx && u_if.uart_rx_valid) begin
            u_if.uart_rx_valid = 1'b0;
            rx_dly = $urandom_range(1, 8);
         end else if (rx_dly > 0) begin
            rx_dly--;
         end
         if (!u_if.uart_rx_valid && rx_dly == 0 && rxq_data.size() > 0) begin
            u_if.uart_rxdata   = rxq_data.pop_front();
            u_if.uart_status   = rxq_stat.pop_front();
            u_if.uart_rx_valid = 1'b1;
         end
      end
   end

   // One transaction: payload[] and resp_buf[] prefilled by the caller.
   task automatic run_txn(input logic [7:0] addr, input int len, input int rlen, input int nsend,
                          input logic [7:0] csum_flip, input int err_idx, input int tmo);
      logic [8:0] exp_tx[$];
      logic [7:0] cs, rcs;
      logic [7:0] wire_rx [0:32];
      int total, ndeliv, cyc;
      logic exp_tmo, exp_erx, exp_ecs;

      @(negedge clk);
      tx_seen.delete(); got.delete();
      pops = 0; dones = 0;
      wr_data = payload[0];

      exp_tx.push_back({1'b1, addr});
      cs = addr;
      for (int i = 0; i < len; i++) begin
         exp_tx.push_back({1'b0, payload[i]});
         cs ^= payload[i];
      end
      if (CSUM != 0) exp_tx.push_back({1'b0, cs});

      total = rlen + CSUM;
      rcs = 8'h00;
      for (int i = 0; i < rlen; i++) begin
         wire_rx[i] = resp_buf[i];
         rcs ^= resp_buf[i];
      end
      wire_rx[rlen] = rcs ^ csum_flip;
      ndeliv  = (nsend < rlen) ? nsend : rlen;
      exp_tmo = (nsend < total);
      exp_erx = (err_idx >= 0) && (err_idx < nsend);
      exp_ecs = (CSUM != 0) && !exp_tmo && (csum_flip != 8'h00);

      req      = 1'b1;
      req_addr = addr;
      req_len  = LEN_W'(len);
      resp_len = LEN_W'(rlen);
      timeout  = TMO_W'(tmo);
      @(negedge clk);
      req = 1'b0;

      cyc = 0;
      while (!(tx_seen.size() >= exp_tx.size() && u_if.uart_tx_empty) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("tx_phase_bound", 32'(cyc < 3000), 32'd1);

      repeat ($urandom_range(4, 10)) @(negedge clk);
      for (int i = 0; i < nsend; i++) begin
         rxq_data.push_back(wire_rx[i]);
         rxq_stat.push_back((i == err_idx) ? 8'h20 : (8'($urandom) & 8'hC3));
      end

      cyc = 0;
      while (dones == 0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_bound", 32'(cyc < 20000), 32'd1);
      repeat (3) @(negedge clk);

      chk("done_pulses", 32'(dones), 32'd1);
      chk("tx_count", 32'(tx_seen.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
         chk("tx_frame", 32'(tx_seen[i]), 32'(exp_tx[i]));
      chk("wr_pop_count", 32'(pops), 32'(len));
      chk("resp_valid_count", 32'(got.size()), 32'(ndeliv));
      for (int i = 0; i < ndeliv && i < got.size(); i++)
         chk("resp_data", 32'(got[i]), 32'(resp_buf[i]));
      chk("resp_count", 32'(resp_count), 32'(ndeliv));
      chk("err_timeout", 32'(err_timeout), 32'(exp_tmo));
      chk("err_rx", 32'(err_rx), 32'(exp_erx));
      chk("err_csum", 32'(err_csum), 32'(exp_ecs));
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int len, rlen, total, nsend, eidx, cnt;
      logic [7:0] flip;

      reset = 1'b1; req = 1'b0; req_addr = '0; req_len = '0; resp_len = '0;
      timeout = '0; wr_data = '0; pops = 0; dones = 0; t_first_resp = 0; t_done = 0;
      for (int i = 0; i < 32; i++) begin payload[i] = 8'h00; resp_buf[i] = 8'h00; end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_pop", 32'(wr_pop), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_count", 32'(resp_count), 32'd0);
      chk("rst_errs", 32'({err_timeout, err_rx, err_csum}), 32'd0);
      chk("rst_control", 32'(u_if.uart_control), 32'h53);
      chk("rst_txdata", 32'(u_if.uart_txdata), 32'h00);
      chk("rst_strobes", 32'({u_if.uart_write_tx, u_if.uart_read_rx}), 32'd0);

      // Address 5A, payload A1 B2, one-byte reply 3C.
      payload[0] = 8'hA1; payload[1] = 8'hB2; resp_buf[0] = 8'h3C;
      run_txn(8'h5A, 2, 1, 1 + CSUM, 8'h00, -1, 200);

      // Address only, no response.
      run_txn(8'h33, 0, 0, CSUM, 8'h00, -1, 200);

      // Two bytes expected, one arrives: timeout about 500 clocks after it.
      resp_buf[0] = 8'h77; resp_buf[1] = 8'h88;
      run_txn(8'h10, 1, 2, 1, 8'h00, -1, 500);
      chk("tmo_latency_window", 32'((t_done - t_first_resp) >= 490 && (t_done - t_first_resp) <= 515), 32'd1);

      // Framing error on the reply still delivers the byte.
      resp_buf[0] = 8'hE5;
      run_txn(8'h42, 1, 1, 1 + CSUM, 8'h00, 0, 200);

      // Checksum case: addr 01, data 02 03; reply 10 11 with corrupted checksum when enabled.
      payload[0] = 8'h02; payload[1] = 8'h03; resp_buf[0] = 8'h10; resp_buf[1] = 8'h11;
      run_txn(8'h01, 2, 2, 2 + CSUM, 8'h21, -1, 200);

      // Reset while sending payload.
      for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
      tx_seen.delete(); pops = 0; wr_data = payload[0];
      req = 1'b1; req_addr = 8'h99; req_len = LEN_W'(4); resp_len = LEN_W'(1); timeout = TMO_W'(200);
      @(negedge clk);
      req = 1'b0;
      cnt = 0;
      while (pops == 0 && cnt < 2000) begin @(negedge clk); cnt++; end
      chk("mid_reset_reach_data", 32'(cnt < 2000), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_reset_busy", 32'(busy), 32'd0);
      chk("mid_reset_control", 32'(u_if.uart_control), 32'h53);
      cnt = tx_seen.size();
      repeat (60) @(negedge clk);
      chk("mid_reset_no_tx", 32'(tx_seen.size()), 32'(cnt));
      chk("mid_reset_no_pop", 32'(pops), 32'd1);

      // Randomized transactions.
      for (int n = 0; n < 14; n++) begin
         len  = $urandom_range(0, 5);
         rlen = $urandom_range(0, 4);
         for (int i = 0; i < 32; i++) begin payload[i] = 8'($urandom); resp_buf[i] = 8'($urandom); end
         total = rlen + CSUM;
         nsend = total;
         if (total > 0 && $urandom_range(0, 3) == 0) nsend = $urandom_range(0, total - 1);
         eidx = -1;
         if (nsend > 0 && $urandom_range(0, 3) == 0) eidx = $urandom_range(0, nsend - 1);
         flip = 8'h00;
         if (CSUM != 0 && $urandom_range(0, 3) == 0) flip = 8'($urandom_range(1, 255));
         run_txn(8'($urandom), len, rlen, nsend, flip, eidx, $urandom_range(60, 120));
      end

      chk("strobe_spacing", 32'(proto_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
